// File: rtl/hsperi_axi_master.sv
// hsperi_axi_master
// 64-bit AXI3-style initiator for the high-speed peripheral slave port.
// Turns a command / write-beat / read-beat stream into a single INCR burst
// of 1..16 beats with one transaction in flight. Write and read data are
// passed straight through; only the command fields are registered.
module hsperi_axi_master #(
    parameter logic [7:0] AXI_ID = 8'h00
) (
    input  logic        acr_clk,
    input  logic        acr_rst,      // async, active-low

    // command stream
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,

    // write beat stream
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb,

    // read beat stream
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [63:0] rd_data,
    output logic        rd_last,

    // completion / status
    output logic        done_valid,
    output logic        done_err,
    output logic        busy,

    // AXI write address
    output logic [31:0] axi_awaddr,
    output logic [3:0]  axi_awlen,
    output logic [2:0]  axi_awsize,
    output logic [1:0]  axi_awburst,
    output logic        axi_awlock,
    output logic [3:0]  axi_awcache,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,

    // AXI write data
    output logic [63:0] axi_wdata,
    output logic [7:0]  axi_wstrb,
    output logic        axi_wlast,
    output logic        axi_wvalid,
    input  logic        axi_wready,

    // AXI write response
    input  logic [7:0]  axi_bid,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,

    // AXI read address
    output logic [7:0]  axi_arid,
    output logic [31:0] axi_araddr,
    output logic [3:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic        axi_arlock,
    output logic [3:0]  axi_arcache,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,

    // AXI read data
    input  logic [7:0]  axi_rid,
    input  logic [63:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;      // beat-aligned start address
    logic [3:0]  r_len;       // beats minus 1
    logic [4:0]  r_cnt;       // beats handshaken so far; 5 bits so 16 fits
    logic        r_err;       // sticky error for the current transaction

    logic [4:0]  w_cnt_nxt;
    logic        w_err_nxt;
    logic        w_cmd_hs;
    logic        w_at_len;
    logic        w_b_bad;
    logic        w_r_bad;

    assign w_cmd_hs = cmd_valid && (r_state == S_IDLE);
    assign w_at_len = (r_cnt == {1'b0, r_len});

    // A response is bad if the slave flags an error or answers for another ID.
    // On reads, an rlast that disagrees with our own beat count is also bad.
    assign w_b_bad  = (axi_bresp != 2'b00) || (axi_bid != AXI_ID);
    assign w_r_bad  = (axi_rresp != 2'b00) || (axi_rid != AXI_ID) ||
                      (axi_rlast != w_at_len);

    // Fixed burst attributes: 8-byte beats, INCR, normal access.
    assign axi_awsize  = 3'b011;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot  = 3'b000;
    assign axi_arsize  = 3'b011;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot  = 3'b000;
    assign axi_arid    = AXI_ID;

    // Address channels present the registered command for the whole wait.
    assign axi_awaddr  = r_addr;
    assign axi_awlen   = r_len;
    assign axi_araddr  = r_addr;
    assign axi_arlen   = r_len;

    // Data is unbuffered; only the handshakes are gated by state.
    assign axi_wdata   = wr_data;
    assign axi_wstrb   = wr_strb;
    assign rd_data     = axi_rdata;

    // State register.
    always_ff @(posedge acr_clk or negedge acr_rst) begin
        if (!acr_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Capture the command on acceptance; low address bits are dropped so
    // every burst starts on a beat boundary.
    always_ff @(posedge acr_clk or negedge acr_rst) begin
        if (!acr_rst) begin
            r_addr <= 32'h0;
            r_len  <= 4'h0;
        end else if (w_cmd_hs) begin
            r_addr <= cmd_addr & 32'hFFFF_FFF8;
            r_len  <= cmd_len;
        end
    end

    // Beat counter and sticky error, both updated from the FSM decode.
    always_ff @(posedge acr_clk or negedge acr_rst) begin
        if (!acr_rst) begin
            r_cnt <= 5'h0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Next-state and handshake decode for all channels.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        wr_ready    = 1'b0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        rd_valid    = 1'b0;
        rd_last     = 1'b0;
        done_valid  = 1'b0;
        done_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    w_state_nxt = cmd_write ? S_AW : S_AR;
            end

            S_AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready)
                    w_state_nxt = S_W;
            end

            S_W: begin
                axi_wvalid = wr_valid;
                wr_ready   = axi_wready;
                axi_wlast  = w_at_len;
                if (wr_valid && axi_wready) begin
                    w_cnt_nxt = r_cnt + 5'd1;
                    if (w_at_len)
                        w_state_nxt = S_B;
                end
            end

            S_B: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    w_err_nxt   = r_err | w_b_bad;
                    w_state_nxt = S_DONE;
                end
            end

            S_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready)
                    w_state_nxt = S_R;
            end

            S_R: begin
                axi_rready = rd_ready;
                rd_valid   = axi_rvalid;
                rd_last    = axi_rlast;
                if (axi_rvalid && rd_ready) begin
                    w_cnt_nxt = r_cnt + 5'd1;
                    w_err_nxt = r_err | w_r_bad;
                    // Stop at whichever end arrives first: the slave's rlast
                    // or our own count. A mismatch was flagged above.
                    if (axi_rlast || w_at_len)
                        w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                done_valid  = 1'b1;
                done_err    = r_err;
                w_cnt_nxt   = 5'h0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hsperi_axi_master.sv
// Bench for hsperi_axi_master: directed vector table, multi-cycle corner
// sequences and randomized transactions against a transaction-level model
// with a behavioural AXI slave.
module tb_hsperi_axi_master;

    logic        acr_clk = 1'b0;
    logic        acr_rst = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [63:0] rd_data;
    logic        done_valid, done_err, busy;
    logic [31:0] axi_awaddr, axi_araddr;
    logic [3:0]  axi_awlen, axi_arlen, axi_awcache, axi_arcache;
    logic [2:0]  axi_awsize, axi_arsize, axi_awprot, axi_arprot;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic        axi_awlock, axi_arlock, axi_awvalid, axi_awready;
    logic [63:0] axi_wdata, axi_rdata;
    logic [7:0]  axi_wstrb, axi_bid, axi_arid, axi_rid;
    logic        axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;

    hsperi_axi_master #(.AXI_ID(8'h00)) dut (
        .acr_clk(acr_clk), .acr_rst(acr_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_err(done_err), .busy(busy),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 acr_clk = ~acr_clk;

    int cyc = 0;
    always @(posedge acr_clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  resp;
        logic [7:0]  id;
        int          rlast_at;   // read beat index carrying rlast
        int          rdmode;     // 0 ready, 1 toggle, 2 random
        int          aw_delay;   // address-channel wait cycles
        logic [63:0] d0;
        logic [7:0]  strb;
        int          exp_err;
        int          exp_beats;
        int          exp_lat;    // 0 = not checked
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tv[$];

    // transaction config and observations
    vec_t        c;
    bit          c_rnd;
    int          c_abort;
    bit          got_done;
    logic        got_err;
    int          acc_cyc, done_cyc, nbeats, aw_hi, bad_aw, data_bad, last_bad;
    int          viol_early, viol_rready, viol_busy;
    logic [31:0] got_addr;
    logic [3:0]  got_alen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input logic [63:0] d0, input int i);
        return d0 + 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    function automatic logic [63:0] rdat(input logic [31:0] a, input int i);
        logic [31:0] x;
        x = a + 32'(i * 8);
        return {x, ~x};
    endfunction

    function automatic vec_t mkv(bit wr, logic [31:0] a, logic [3:0] l, logic [1:0] rs,
                                 logic [7:0] id, int rl, int rm, int awd,
                                 logic [63:0] d0, logic [7:0] st,
                                 int ee, int eb, int el, logic [31:0] ea);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.resp = rs; v.id = id;
        v.rlast_at = rl; v.rdmode = rm; v.aw_delay = awd; v.d0 = d0; v.strb = st;
        v.exp_err = ee; v.exp_beats = eb; v.exp_lat = el; v.exp_addr = ea;
        return v;
    endfunction

    task automatic drive_idle();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
        axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0; axi_rid = 0; axi_rdata = 0;
    endtask

    // Runs one transaction cycle by cycle: samples at negedge, drives host
    // and slave at posedge+1.
    task automatic run_txn();
        bit h_cmd, h_aw, h_w, h_b, h_ar, h_r, h_rlast, h_awv, h_arv;
        bit accepted, aw_done, r_active, r_win;
        int aw_cnt, ar_cnt, wbeat, sw_cnt, r_beat, s_cyc;
        logic [31:0] s_base, ea;
        logic [3:0]  s_alen, s_rlen;
        accepted = 0; aw_done = 0; r_active = 0; r_win = 0;
        aw_cnt = 0; ar_cnt = 0; wbeat = 0; sw_cnt = 0; r_beat = 0;
        s_base = 0; s_alen = 0; s_rlen = 0;
        got_done = 0; got_err = 0; nbeats = 0; aw_hi = 0; bad_aw = 0;
        data_bad = 0; last_bad = 0; viol_early = 0; viol_rready = 0; viol_busy = 0;
        got_addr = 0; got_alen = 0; acc_cyc = 0; done_cyc = 0;
        ea = c.addr & 32'hFFFF_FFF8;

        cmd_valid = 1; cmd_write = c.wr; cmd_addr = c.addr; cmd_len = c.len;
        wr_valid = c.wr; wr_data = wdat(c.d0, 0); wr_strb = c.strb;
        rd_ready = 1; axi_wready = 1;
        axi_awready = (c.aw_delay == 0);
        axi_arready = (c.aw_delay == 0);

        for (int b = 0; b < 400 && !got_done; b++) begin
            @(negedge acr_clk);
            s_cyc   = cyc;
            h_cmd   = cmd_valid && cmd_ready;
            h_awv   = axi_awvalid;
            h_arv   = axi_arvalid;
            h_aw    = axi_awvalid && axi_awready;
            h_w     = axi_wvalid && axi_wready;
            h_b     = axi_bvalid && axi_bready;
            h_ar    = axi_arvalid && axi_arready;
            h_r     = axi_rvalid && axi_rready;
            h_rlast = axi_rlast;
            if (h_cmd) acc_cyc = s_cyc;
            if (axi_awvalid || axi_arvalid) begin
                aw_hi++;
                if ((axi_awvalid && (axi_awaddr !== ea || axi_awlen !== c.len)) ||
                    (axi_arvalid && (axi_araddr !== ea || axi_arlen !== c.len)))
                    bad_aw++;
            end
            if (h_aw) begin got_addr = axi_awaddr; got_alen = axi_awlen; s_alen = axi_awlen; end
            if (h_ar) begin got_addr = axi_araddr; got_alen = axi_arlen;
                            s_base = axi_araddr; s_rlen = axi_arlen; end
            if (!aw_done && (axi_wvalid || wr_ready)) viol_early++;
            if (r_win && axi_rready !== rd_ready) viol_rready++;
            if (accepted && !busy) viol_busy++;
            if (h_w) begin
                if (axi_wdata !== wdat(c.d0, nbeats) || axi_wstrb !== c.strb) data_bad++;
                if (axi_wlast !== (nbeats == int'(c.len))) last_bad++;
                nbeats++;
            end
            if (rd_valid && rd_ready) begin
                if (rd_data !== rdat(ea, nbeats)) data_bad++;
                if (rd_last !== (nbeats == c.rlast_at)) last_bad++;
                nbeats++;
            end
            if (done_valid) begin got_done = 1; got_err = done_err; done_cyc = s_cyc; end

            @(posedge acr_clk); #1;
            if (c_abort > 0 && nbeats == c_abort - 1) begin
                acr_rst = 0;
                #1;
                chk("abort_wvalid", axi_wvalid, 0);
                chk("abort_awvalid", axi_awvalid, 0);
                chk("abort_bready", axi_bready, 0);
                chk("abort_cmd_ready", cmd_ready, 1);
                drive_idle();
                repeat (2) @(posedge acr_clk);
                #1 acr_rst = 1;
                @(posedge acr_clk); #1;
                return;
            end
            if (h_cmd) begin cmd_valid = 0; accepted = 1; end
            // address channels
            if (h_aw) begin aw_done = 1; aw_cnt = 0; end else if (h_awv) aw_cnt++;
            if (h_ar) begin aw_done = 1; ar_cnt = 0; r_active = 1; r_win = 1; r_beat = 0; end
            else if (h_arv) ar_cnt++;
            axi_awready = (aw_cnt >= c.aw_delay);
            axi_arready = (ar_cnt >= c.aw_delay);
            // write data / response
            if (h_w) begin
                wbeat++;
                if (sw_cnt == int'(s_alen)) begin
                    axi_bvalid = 1; axi_bresp = c.resp; axi_bid = c.id;
                end
                sw_cnt++;
            end
            if (h_b) axi_bvalid = 0;
            wr_valid = c.wr && (wbeat <= int'(c.len)) && (!c_rnd || $urandom_range(0, 3) != 0);
            wr_data  = wdat(c.d0, wbeat);
            axi_wready = !c_rnd || ($urandom_range(0, 3) != 0);
            // read data
            if (h_r) begin
                if (h_rlast || r_beat == int'(s_rlen)) begin r_active = 0; r_win = 0; end
                else r_beat++;
            end
            axi_rvalid = r_active && (!c_rnd || $urandom_range(0, 3) != 0);
            axi_rdata  = rdat(s_base, r_beat);
            axi_rlast  = (r_beat == c.rlast_at);
            axi_rresp  = c.resp;
            axi_rid    = c.id;
            case (c.rdmode)
                0:       rd_ready = 1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
        drive_idle();
        chk("done_seen", got_done, 1);
        @(negedge acr_clk);
        chk("post_done", {done_valid, cmd_ready, busy}, 3'b010);
        @(posedge acr_clk); #1;
    endtask

    task automatic apply_vec(input vec_t v, input bit rnd, input string tag);
        c = v; c_rnd = rnd; c_abort = 0;
        run_txn();
        chk({tag, "_err"}, got_err, v.exp_err[0]);
        chk({tag, "_beats"}, nbeats, v.exp_beats);
        chk({tag, "_addr"}, got_addr, v.exp_addr);
        chk({tag, "_alen"}, got_alen, v.len);
        chk({tag, "_aw_stable"}, bad_aw, 0);
        chk({tag, "_data"}, data_bad, 0);
        chk({tag, "_last"}, last_bad, 0);
        chk({tag, "_w_early"}, viol_early, 0);
        chk({tag, "_rready"}, viol_rready, 0);
        chk({tag, "_busy"}, viol_busy, 0);
        if (v.exp_lat != 0) chk({tag, "_lat"}, done_cyc - acc_cyc, v.exp_lat);
    endtask

    initial begin
        vec_t v;
        int   rl;
        drive_idle();
        acr_rst = 0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready,
                           rd_valid, wr_ready, done_valid, done_err}, 0);
        chk("rst_addr", {axi_awaddr, axi_awlen, axi_arlen}, 0);
        chk("rst_aw_const", {axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot},
            {3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
        chk("rst_ar_const", {axi_arid, axi_arsize, axi_arburst, axi_arlock, axi_arcache,
                             axi_arprot}, {8'h00, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
        @(posedge acr_clk); #1 acr_rst = 1;
        repeat (2) @(posedge acr_clk);
        #1;

        //          wr addr           len rsp   id    rl rm awd d0                      strb   err bt lat exp_addr
        tv.push_back(mkv(1, 32'h0000_1004, 0, 0, 8'h00, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 1, 4, 32'h0000_1000));
        tv.push_back(mkv(0, 32'h0000_2000, 15, 0, 8'h00, 15, 1, 0, 64'h0, 8'h00, 0, 16, 0, 32'h0000_2000));
        tv.push_back(mkv(1, 32'h0000_3008, 2, 2'b10, 8'h00, 2, 0, 0, 64'h1111_2222_3333_4444, 8'h0F, 1, 3, 0, 32'h0000_3008));
        tv.push_back(mkv(1, 32'h0000_3010, 0, 0, 8'h00, 0, 0, 0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hF0, 0, 1, 4, 32'h0000_3010));
        tv.push_back(mkv(0, 32'h0000_4000, 3, 0, 8'h00, 1, 0, 0, 64'h0, 8'h00, 1, 2, 0, 32'h0000_4000));
        tv.push_back(mkv(0, 32'h0000_5000, 0, 0, 8'h05, 0, 0, 0, 64'h0, 8'h00, 1, 1, 3, 32'h0000_5000));
        tv.push_back(mkv(0, 32'h0000_600F, 0, 0, 8'h00, 0, 0, 0, 64'h0, 8'h00, 0, 1, 3, 32'h0000_6008));
        tv.push_back(mkv(0, 32'h0000_6100, 2, 2'b11, 8'h00, 2, 0, 0, 64'h0, 8'h00, 1, 3, 0, 32'h0000_6100));
        tv.push_back(mkv(1, 32'hFFFF_FFF9, 7, 0, 8'h03, 7, 0, 0, 64'h0123_4567_89AB_CDEF, 8'h3C, 1, 8, 0, 32'hFFFF_FFF8));
        tv.push_back(mkv(0, 32'h0000_7000, 4, 0, 8'h00, 9, 0, 0, 64'h0, 8'h00, 1, 5, 0, 32'h0000_7000));
        foreach (tv[i]) apply_vec(tv[i], 0, $sformatf("vec%0d", i));

        // awready held off 5 cycles: awvalid stays up 6 cycles, no early W
        apply_vec(mkv(1, 32'h0000_8000, 1, 0, 8'h00, 1, 0, 5, 64'h5555_0000_AAAA_0000, 8'hFF,
                      0, 2, 0, 32'h0000_8000), 0, "awdelay");
        chk("awdelay_hi", aw_hi, 6);
        apply_vec(mkv(0, 32'h0000_8100, 0, 0, 8'h00, 0, 0, 5, 64'h0, 8'h00,
                      0, 1, 8, 32'h0000_8100), 0, "ardelay");

        // reset during beat 4 of an 8-beat write, then a clean write
        c = mkv(1, 32'h0000_9000, 7, 0, 8'h00, 7, 0, 0, 64'h7777_0000_0000_0001, 8'hFF,
                0, 8, 0, 32'h0000_9000);
        c_rnd = 0; c_abort = 4;
        run_txn();
        apply_vec(mkv(1, 32'h0000_9100, 0, 0, 8'h00, 0, 0, 0, 64'h0BAD_F00D_0000_0001, 8'hFF,
                      0, 1, 4, 32'h0000_9100), 0, "post_rst");

        // randomized transactions against the transaction-level model
        for (int k = 0; k < 40; k++) begin
            v.wr       = ($urandom_range(0, 1) == 1);
            v.addr     = $urandom;
            v.len      = 4'($urandom_range(0, 15));
            v.resp     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.id       = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            rl         = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(v.len);
            v.rlast_at = rl;
            v.rdmode   = 2;
            v.aw_delay = $urandom_range(0, 3);
            v.d0       = {$urandom, $urandom};
            v.strb     = 8'($urandom);
            v.exp_addr = v.addr & 32'hFFFF_FFF8;
            v.exp_lat  = 0;
            if (v.wr) begin
                v.exp_beats = int'(v.len) + 1;
                v.exp_err   = (v.resp != 0 || v.id != 8'h00) ? 1 : 0;
            end else begin
                v.exp_beats = ((rl < int'(v.len)) ? rl : int'(v.len)) + 1;
                v.exp_err   = (v.resp != 0 || v.id != 8'h00 || rl != int'(v.len)) ? 1 : 0;
            end
            apply_vec(v, 1, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
